// File: rtl/matmul_controller.sv
// Job sequencer for a systolic matmul array frame.
// Walks each job through CLEAR -> RUN -> DRAIN -> DONE, guards RUN with a
// watchdog that parks the block in ERR, and counts completed jobs.
// Every output is a flop, loaded from the next-state view of the FSM so
// that the outputs always describe the state the FSM is currently in.
module matmul_controller #(
    parameter int  MATRIX_SIZE    = 2,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int AW             = ($clog2(MATRIX_SIZE) < 1) ? 1 : $clog2(MATRIX_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          array_finished,
    output logic          array_clear,
    output logic          array_enable,
    output logic [AW-1:0] feed_addr,
    output logic          feed_valid,
    output logic          result_valid,
    output logic [AW-1:0] result_row,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   jobs_done
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE, ERR} state_t;

    localparam logic [15:0]   WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]   FEED_N   = 16'(MATRIX_SIZE);
    localparam logic [AW-1:0] ROW_LAST = AW'(MATRIX_SIZE - 1);

    state_t        state, state_nx;
    logic [15:0]   wdog, wdog_nx;          // index of the current RUN cycle
    logic [AW-1:0] drain_cnt, drain_nx;    // index of the current DRAIN cycle
    logic          clear_nx, enable_nx, fv_nx, rv_nx, busy_nx, done_nx, err_nx;
    logic [AW-1:0] fa_nx;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state (abort outranks everything) and next values of all outputs.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !abort) state_nx = CLEAR;
            CLEAR:   state_nx = abort ? IDLE : RUN;
            RUN: begin
                if (abort)                state_nx = IDLE;
                else if (array_finished)  state_nx = DRAIN;
                else if (wdog == WD_LAST) state_nx = ERR;
            end
            DRAIN: begin
                if (abort)                      state_nx = IDLE;
                else if (drain_cnt == ROW_LAST) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            ERR:     if (abort) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Counters restart at 0 on entry to their state and read 0 elsewhere.
        wdog_nx  = '0;
        drain_nx = '0;
        if (state_nx == RUN && state == RUN)     wdog_nx  = wdog + 16'd1;
        if (state_nx == DRAIN && state == DRAIN) drain_nx = drain_cnt + AW'(1);

        clear_nx  = (state_nx == CLEAR);
        enable_nx = (state_nx == RUN);
        fv_nx     = (state_nx == RUN) && (wdog_nx < FEED_N);
        fa_nx     = '0;
        if (state_nx == RUN) fa_nx = (wdog_nx < FEED_N) ? AW'(wdog_nx) : ROW_LAST;
        rv_nx     = (state_nx == DRAIN);
        busy_nx   = (state_nx != IDLE);
        done_nx   = (state_nx == DONE);
        err_nx    = (state_nx == ERR);
    end

    // Output flops, per-job counters and the completed-job counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog         <= '0;
            drain_cnt    <= '0;
            array_clear  <= 1'b0;
            array_enable <= 1'b0;
            feed_addr    <= '0;
            feed_valid   <= 1'b0;
            result_valid <= 1'b0;
            result_row   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            jobs_done    <= '0;
        end else begin
            wdog         <= wdog_nx;
            drain_cnt    <= drain_nx;
            array_clear  <= clear_nx;
            array_enable <= enable_nx;
            feed_addr    <= fa_nx;
            feed_valid   <= fv_nx;
            result_valid <= rv_nx;
            result_row   <= drain_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            error        <= err_nx;
            // A job counts only when DONE is left without an abort.
            if (state == DONE && !abort) jobs_done <= jobs_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller: each job is described as a list of phases
// (CLEAR, RUN k, DRAIN k, DONE, ERR) built from the job rules, and the DUT
// outputs are compared against that list cycle by cycle.
`timescale 1ns/1ps
module tb_matmul_controller;

    localparam int N  = 2;
    localparam int TO = 64;
    localparam int AW = ($clog2(N) < 1) ? 1 : $clog2(N);

    localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4, P_ERR = 5;

    typedef struct packed {
        logic          clr;
        logic          en;
        logic [AW-1:0] fa;
        logic          fv;
        logic          rv;
        logic [AW-1:0] rr;
        logic          busy;
        logic          dn;
        logic          err;
    } obs_t;

    typedef struct {
        int ph;
        int idx;
    } step_t;

    logic          clk = 1'b0;
    logic          reset, start, abort, array_finished;
    logic          array_clear, array_enable, feed_valid, result_valid;
    logic          busy, done, error;
    logic [AW-1:0] feed_addr, result_row;
    logic [15:0]   jobs_done;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] model_jobs = '0;

    always #5 clk = ~clk;

    matmul_controller #(.MATRIX_SIZE(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .array_finished(array_finished), .array_clear(array_clear),
        .array_enable(array_enable), .feed_addr(feed_addr), .feed_valid(feed_valid),
        .result_valid(result_valid), .result_row(result_row), .busy(busy),
        .done(done), .error(error), .jobs_done(jobs_done)
    );

    function automatic obs_t observe();
        return {array_clear, array_enable, feed_addr, feed_valid, result_valid,
                result_row, busy, done, error};
    endfunction

    function automatic obs_t expect_of(int ph, int idx);
        obs_t e = '0;
        case (ph)
            P_CLEAR: begin e.clr = 1'b1; e.busy = 1'b1; end
            P_RUN: begin
                e.en   = 1'b1;
                e.fa   = AW'((idx < N) ? idx : N - 1);
                e.fv   = (idx < N);
                e.busy = 1'b1;
            end
            P_DRAIN: begin e.rv = 1'b1; e.rr = AW'(idx); e.busy = 1'b1; end
            P_DONE:  begin e.dn = 1'b1; e.busy = 1'b1; end
            P_ERR:   begin e.err = 1'b1; e.busy = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    // Runs one job from IDLE. fin: RUN cycle (1-based) carrying array_finished,
    // 0 = never. abort_at: phase index receiving abort, -1 = none.
    // mode 0 quiet, 1 start held high, 2 random start/finished noise.
    task automatic run_job(input string tag, input int fin, input int abort_at,
                           input int err_hold, input int mode);
        step_t q[$];
        obs_t  got, want;
        bit    completes;
        q.push_back('{P_CLEAR, 0});
        if (fin >= 1 && fin <= TO) begin
            for (int k = 0; k < fin; k++) q.push_back('{P_RUN, k});
            for (int k = 0; k < N; k++)   q.push_back('{P_DRAIN, k});
            q.push_back('{P_DONE, 0});
        end else begin
            for (int k = 0; k < TO; k++)       q.push_back('{P_RUN, k});
            for (int k = 0; k < err_hold; k++) q.push_back('{P_ERR, 0});
        end
        if (abort_at < 0 && q[q.size()-1].ph == P_ERR) abort_at = q.size() - 1;
        if (abort_at >= 0 && abort_at < q.size() - 1) q = q[0:abort_at];
        completes = (q[q.size()-1].ph == P_DONE) && (abort_at != q.size() - 1);

        start = 1'b1; abort = 1'b0; array_finished = 1'b0;
        @(posedge clk); #1;
        foreach (q[i]) begin
            got  = observe();
            want = expect_of(q[i].ph, q[i].idx);
            n_checks++;
            if (got !== want)
                $display("FAIL %s step %0d (phase %0d.%0d): got %b want %b",
                         tag, i, q[i].ph, q[i].idx, got, want);
            else n_pass++;
            start = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            abort = (i == abort_at);
            if (q[i].ph == P_RUN) array_finished = (q[i].idx == fin - 1);
            else array_finished = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; array_finished = 1'b0;
        if (completes) model_jobs = model_jobs + 16'd1;
        got = observe();
        n_checks++;
        if (got !== obs_t'('0)) $display("FAIL %s idle: got %b want 0", tag, got);
        else n_pass++;
        n_checks++;
        if (jobs_done !== model_jobs)
            $display("FAIL %s jobs_done: got %h want %h", tag, jobs_done, model_jobs);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; array_finished = 1'b0;
        #2;
        n_checks++;
        if (observe() !== obs_t'('0)) $display("FAIL reset_outputs: got %b want 0", observe());
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (jobs_done !== 16'h0) $display("FAIL reset_jobs: got %h want 0000", jobs_done);
        else n_pass++;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_nominal();
        run_job("nominal", 5, -1, 0, 0);
    endtask

    task automatic test_timeout();
        run_job("timeout", 0, -1, 5, 0);
    endtask

    task automatic test_abort_mid();
        run_job("abort_run3", 5, 3, 0, 0);
    endtask

    task automatic test_busy_start();
        run_job("start_busy", 5, -1, 0, 1);
        for (int c = 0; c < 3; c++) begin
            start = 1'b1; abort = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (observe() !== obs_t'('0)) $display("FAIL start_abort_idle: got %b want 0", observe());
            else n_pass++;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_priority();
        run_job("drain_beats_timeout", TO, -1, 0, 0);
        run_job("abort_clear", 4, 0, 0, 0);
        run_job("abort_beats_finish", 4, 4, 0, 0);
        run_job("abort_drain", 4, 5, 0, 0);
        run_job("abort_done", 3, 3 + N + 1, 0, 0);
        run_job("abort_first_err", 0, TO + 1, 3, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            int fin = $urandom_range(0, TO);
            int eh  = $urandom_range(1, 4);
            int len = 1 + ((fin == 0) ? TO + eh : fin + N + 1);
            int ab  = -1;
            if ($urandom_range(0, 2) == 0) ab = $urandom_range(0, len - 1);
            run_job("random", fin, ab, eh, 2);
        end
    endtask

    // Preloads the counter near its top instead of running 65534 jobs.
    task automatic test_wrap();
        force dut.jobs_done = 16'hFFFE;
        @(posedge clk); #1;
        release dut.jobs_done;
        model_jobs = 16'hFFFE;
        run_job("wrap_ffff", 2, -1, 0, 0);
        run_job("wrap_0000", 3, -1, 0, 0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        model_jobs = '0;
        n_checks++;
        if (observe() !== obs_t'('0)) $display("FAIL reset_mid_outputs: got %b want 0", observe());
        else n_pass++;
        n_checks++;
        if (jobs_done !== model_jobs) $display("FAIL reset_mid_jobs: got %h want %h", jobs_done, model_jobs);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0) $display("FAIL reset_mid_done: got %b want 0", done);
            else n_pass++;
        end
        @(negedge clk) reset = 1'b0;
        run_job("after_reset", 5, -1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_abort_mid();
        test_busy_start();
        test_priority();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case the bench itself stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
